victim_cache_ctrl: RTL and testbench
====================================

VICTIM_CACHE_CTRL -- requirements
Module: victim_cache_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high, named clk and reset.
REQ-002 SHALL have ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- lk_req_valid  in  1  lookup request
- lk_req_ready  out  1  lookup accepted this cycle
- lk_page_offset  in  12  lookup page offset
- lk_rsp_valid  out  1  one-cycle lookup response pulse
- lk_rsp_hit  out  1  lookup hit
- lk_rsp_byte  out  8  lookup byte
- ev_req_valid  in  1  L1-eviction insert request
- ev_req_ready  out  1  insert accepted this cycle
- ev_page_offset  in  12  insert page offset
- ev_data  in  512  block to insert
- vc_page_offset  out  12  to victim cache page_offset
- vc_data_in  out  512  to victim cache data_in
- vc_write_en  out  1  to victim cache write_en
- vc_is_found  in  1  from victim cache is_found
- vc_byte_out  in  8  from victim cache byte_out
- vc_block_out  in  512  from victim cache block_out
- wb_valid  out  1  evicted block pending for L2
- wb_ready  in  1  L2 accepts evicted block
- wb_data  out  512  evicted block

Function
REQ-003 SHALL issue at most one operation per cycle; an op is issued in the cycle its req_valid and req_ready are both high; vc_* are combinational from the granted request, vc_write_en=0 and vc_page_offset/vc_data_in=0 when nothing is issued.
REQ-004 SHALL treat victim-cache latency as VC_LAT=3: results of an op issued in cycle N are sampled from vc_is_found, vc_byte_out and vc_block_out in cycle N+3.
REQ-005 SHALL track in-flight ops in a VC_LAT-deep shift register of {valid, is_write}, advancing every cycle.
REQ-006 SHALL pulse lk_rsp_valid for exactly one cycle at N+3 for a lookup issued at N, with lk_rsp_hit=vc_is_found and lk_rsp_byte=vc_byte_out; hit=0 forces byte=0; there is no response backpressure.
REQ-007 SHALL, at N+3 for an insert, capture vc_block_out into a one-entry writeback buffer iff vc_is_found=1 (valid victim evicted); otherwise no writeback.
REQ-008 SHALL run writeback FSM WB_EMPTY->WB_FULL on capture and WB_FULL->WB_EMPTY on wb_valid&&wb_ready; wb_valid=1 only in WB_FULL; wb_data holds stable while WB_FULL.
REQ-009 SHALL hold ev_req_ready=0 while WB_FULL or while any insert is in flight, so a capture never meets a full buffer.
REQ-010 SHALL arbitrate round-robin when both requesters are eligible: grant the one not granted last; a sole eligible requester always wins; last_grant updates only on an actual issue.
REQ-011 SHALL make lk_req_ready and ev_req_ready combinational from eligibility and arbitration, never both high in the same cycle.

Reset
REQ-012 SHALL on reset clear the in-flight register, WB FSM to WB_EMPTY, last_grant to insert (lookup wins first tie); all outputs 0 during and one cycle after reset.
REQ-013 SHALL drop in-flight ops on reset mid-operation: no lk_rsp_valid and no wb capture for them.

Configuration
REQ-014 SHALL, with VC_CTRL_STATS_EN defined, add outputs stat_hits and stat_misses (16 bits, saturating at 16'hFFFF, cleared by reset) counting lookup responses by lk_rsp_hit; without the macro these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-015 SHALL place VC_LAT, op-type typedef and WB state enum in shared package victim_cache_pkg; the round-robin grant logic SHALL be sub-module rr_arb2.

Verification
REQ-016 SHALL cover:
- lookup 12'h0C5 at cycle 10, vc_is_found=1, vc_byte_out=8'hA7 at cycle 13 -> lk_rsp_valid pulse at 13, hit=1, byte=8'hA7.
- lk and ev valid together from idle after reset -> lookup granted, insert next cycle, then alternating.
- insert with vc_is_found=1, block=512'h5A.. at N+3, wb_ready=0 for 5 cycles -> wb_valid stays 1, wb_data stable, ev_req_ready=0 until handshake.
- insert with vc_is_found=0 at N+3 -> wb_valid stays 0, ev_req_ready returns to 1 at N+3.
- reset asserted at N+1 after a lookup -> no lk_rsp_valid at N+3, all outputs 0.

Source files
------------

// File: rtl/victim_cache_pkg.sv
// Shared types and widths for the victim cache controller.
package victim_cache_pkg;

    localparam int unsigned VC_LAT = 3;
    localparam int unsigned OFF_W  = 12;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BLK_W  = 512;
    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        OP_LOOKUP = 1'b0,
        OP_INSERT = 1'b1
    } op_e;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic valid;
        op_e  op;
    } inflight_t;

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// Request, victim-cache and writeback signals of the controller.
// VC_CTRL_STATS_EN adds the hit/miss statistic outputs.
interface victim_cache_ctrl_if;
    import victim_cache_pkg::*;

    logic                lk_req_valid;
    logic                lk_req_ready;
    logic [OFF_W-1:0]    lk_page_offset;
    logic                lk_rsp_valid;
    logic                lk_rsp_hit;
    logic [BYTE_W-1:0]   lk_rsp_byte;
    logic                ev_req_valid;
    logic                ev_req_ready;
    logic [OFF_W-1:0]    ev_page_offset;
    logic [BLK_W-1:0]    ev_data;
    logic [OFF_W-1:0]    vc_page_offset;
    logic [BLK_W-1:0]    vc_data_in;
    logic                vc_write_en;
    logic                vc_is_found;
    logic [BYTE_W-1:0]   vc_byte_out;
    logic [BLK_W-1:0]    vc_block_out;
    logic                wb_valid;
    logic                wb_ready;
    logic [BLK_W-1:0]    wb_data;
`ifdef VC_CTRL_STATS_EN
    logic [STAT_W-1:0]   stat_hits;
    logic [STAT_W-1:0]   stat_misses;
`endif

    modport master (
        output lk_req_valid, lk_page_offset, ev_req_valid, ev_page_offset, ev_data,
        output vc_is_found, vc_byte_out, vc_block_out, wb_ready,
`ifdef VC_CTRL_STATS_EN
        input  stat_hits, stat_misses,
`endif
        input  lk_req_ready, lk_rsp_valid, lk_rsp_hit, lk_rsp_byte, ev_req_ready,
        input  vc_page_offset, vc_data_in, vc_write_en, wb_valid, wb_data
    );

    modport slave (
        input  lk_req_valid, lk_page_offset, ev_req_valid, ev_page_offset, ev_data,
        input  vc_is_found, vc_byte_out, vc_block_out, wb_ready,
`ifdef VC_CTRL_STATS_EN
        output stat_hits, stat_misses,
`endif
        output lk_req_ready, lk_rsp_valid, lk_rsp_hit, lk_rsp_byte, ev_req_ready,
        output vc_page_offset, vc_data_in, vc_write_en, wb_valid, wb_data
    );

endinterface

// File: rtl/victim_cache_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is lookup, bit 1 is insert.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o
);

    logic last_q, last_d;  // 1: insert was granted last

    always_comb begin
        gnt_c_o = 2'b00;
        last_d  = last_q;
        if (req_i == 2'b11) begin
            gnt_c_o = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt_c_o = req_i;
        end
        if (|gnt_c_o) begin
            last_d = gnt_c_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: arbitrates lookups/inserts, tracks VC latency, buffers evictions.
// Optional VC_CTRL_STATS_EN adds saturating lookup hit/miss counters.
module victim_cache_ctrl
    import victim_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    victim_cache_ctrl_if.slave bus
);

    inflight_t [VC_LAT-1:0] pipe_q, pipe_d;
    wb_state_e              wb_state_q, wb_state_d;
    logic [BLK_W-1:0]       wb_buf_q, wb_buf_d;
    logic                   ready_en_q;
    logic [1:0]             req_c, gnt_c;
    logic                   head_lk_c, head_ins_c, capture_c, ins_busy_c;
    logic                   rsp_valid_c, rsp_hit_c;

    // The oldest pipe entry is the op whose victim-cache result is on the bus now.
    assign head_lk_c  = pipe_q[VC_LAT-1].valid && (pipe_q[VC_LAT-1].op == OP_LOOKUP);
    assign head_ins_c = pipe_q[VC_LAT-1].valid && (pipe_q[VC_LAT-1].op == OP_INSERT);
    assign capture_c  = !reset && head_ins_c && bus.vc_is_found;

    // A landing insert only frees the slot if it does not fill the writeback buffer.
    always_comb begin
        ins_busy_c = head_ins_c && bus.vc_is_found;
        for (int unsigned i = 0; i < VC_LAT - 1; i++) begin
            if (pipe_q[i].valid && (pipe_q[i].op == OP_INSERT)) begin
                ins_busy_c = 1'b1;
            end
        end
    end

    assign req_c[0] = !reset && ready_en_q && bus.lk_req_valid;
    assign req_c[1] = !reset && ready_en_q && bus.ev_req_valid
                      && (wb_state_q == WB_EMPTY) && !ins_busy_c;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_c),
        .gnt_c_o (gnt_c)
    );

    assign rsp_valid_c = !reset && head_lk_c;
    assign rsp_hit_c   = rsp_valid_c && bus.vc_is_found;

    always_comb begin
        bus.lk_req_ready   = gnt_c[0];
        bus.ev_req_ready   = gnt_c[1];
        bus.vc_write_en    = gnt_c[1];
        bus.vc_page_offset = '0;
        bus.vc_data_in     = '0;
        if (gnt_c[0]) begin
            bus.vc_page_offset = bus.lk_page_offset;
        end
        if (gnt_c[1]) begin
            bus.vc_page_offset = bus.ev_page_offset;
            bus.vc_data_in     = bus.ev_data;
        end
        bus.lk_rsp_valid = rsp_valid_c;
        bus.lk_rsp_hit   = rsp_hit_c;
        bus.lk_rsp_byte  = rsp_hit_c ? bus.vc_byte_out : '0;
        bus.wb_valid     = !reset && (wb_state_q == WB_FULL);
        bus.wb_data      = reset ? '0 : wb_buf_q;
    end

    always_comb begin
        pipe_d          = '0;
        pipe_d[0].valid = |gnt_c;
        pipe_d[0].op    = gnt_c[1] ? OP_INSERT : OP_LOOKUP;
        for (int unsigned i = 1; i < VC_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        wb_state_d = wb_state_q;
        wb_buf_d   = wb_buf_q;
        case (wb_state_q)
            WB_EMPTY: begin
                if (capture_c) begin
                    wb_state_d = WB_FULL;
                    wb_buf_d   = bus.vc_block_out;
                end
            end
            WB_FULL: begin
                if (bus.wb_ready) begin
                    wb_state_d = WB_EMPTY;
                end
            end
        endcase
    end

    // ready_en_q keeps both requesters blocked for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q     <= '0;
            wb_state_q <= WB_EMPTY;
            wb_buf_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            wb_state_q <= wb_state_d;
            wb_buf_q   <= wb_buf_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef VC_CTRL_STATS_EN
    logic [STAT_W-1:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (rsp_valid_c) begin
            if (rsp_hit_c) begin
                hits_q <= (hits_q == '1) ? hits_q : hits_q + STAT_W'(1);
            end else begin
                misses_q <= (misses_q == '1) ? misses_q : misses_q + STAT_W'(1);
            end
        end
    end

    assign bus.stat_hits   = hits_q;
    assign bus.stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Bench for victim_cache_ctrl: directed scenarios plus random traffic against a cycle-count model.
// Define VC_CTRL_STATS_EN to also check the statistic outputs.
module tb_victim_cache_ctrl;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    victim_cache_ctrl_if bus ();

    victim_cache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Stimulus for the next cycle.
    logic         s_reset;
    logic         s_lk_v, s_ev_v, s_found, s_wb_ready;
    logic [11:0]  s_lk_off, s_ev_off;
    logic [7:0]   s_byte;
    logic [511:0] s_ev_data, s_block;

    // Reference model: issue cycles of outstanding ops, writeback buffer, last winner.
    int           cyc = 0;
    bit           m_after_rst;
    int           lk_q[$];
    int           ins_q[$];
    bit           m_wb_full;
    logic [511:0] m_wb_data;
    bit           m_last_ins;
    int           m_hits, m_misses;

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_check();
        bit en, lk_land, ins_land, cap, busy, lk_el, ev_el, g_lk, g_ev;
        logic [11:0] exp_off;
        if (reset) begin
            check("rst_lk_ready", bus.lk_req_ready, 0);
            check("rst_ev_ready", bus.ev_req_ready, 0);
            check("rst_rsp_valid", bus.lk_rsp_valid, 0);
            check("rst_wb_valid", bus.wb_valid, 0);
            check("rst_vc_we", bus.vc_write_en, 0);
            check("rst_vc_off", bus.vc_page_offset, 0);
            check("rst_wb_data", bus.wb_data, 0);
            lk_q.delete();
            ins_q.delete();
            m_wb_full   = 0;
            m_wb_data   = '0;
            m_last_ins  = 1;
            m_after_rst = 1;
            m_hits      = 0;
            m_misses    = 0;
            return;
        end
        en       = !m_after_rst;
        lk_land  = (lk_q.size() > 0) && (lk_q[0] == cyc - LAT);
        ins_land = (ins_q.size() > 0) && (ins_q[0] == cyc - LAT);
        cap      = ins_land && s_found;
        busy     = cap;
        foreach (ins_q[i]) if (cyc - ins_q[i] < LAT) busy = 1;
        lk_el = en && s_lk_v;
        ev_el = en && s_ev_v && !m_wb_full && !busy;
        if (lk_el && ev_el) begin
            g_lk = m_last_ins;
            g_ev = !m_last_ins;
        end else begin
            g_lk = lk_el;
            g_ev = ev_el;
        end
        exp_off = g_lk ? s_lk_off : (g_ev ? s_ev_off : 12'h000);

        check("lk_req_ready", bus.lk_req_ready, g_lk);
        check("ev_req_ready", bus.ev_req_ready, g_ev);
        check("vc_write_en", bus.vc_write_en, g_ev);
        check("vc_page_offset", bus.vc_page_offset, exp_off);
        check("vc_data_in", bus.vc_data_in, g_ev ? s_ev_data : 512'h0);
        check("lk_rsp_valid", bus.lk_rsp_valid, lk_land);
        check("lk_rsp_hit", bus.lk_rsp_hit, lk_land && s_found);
        check("lk_rsp_byte", bus.lk_rsp_byte, (lk_land && s_found) ? s_byte : 8'h00);
        check("wb_valid", bus.wb_valid, m_wb_full);
        if (m_wb_full) check("wb_data", bus.wb_data, m_wb_data);
`ifdef VC_CTRL_STATS_EN
        check("stat_hits", bus.stat_hits, (m_hits > 65535) ? 65535 : m_hits);
        check("stat_misses", bus.stat_misses, (m_misses > 65535) ? 65535 : m_misses);
`endif

        if (lk_land) begin
            void'(lk_q.pop_front());
            if (s_found) m_hits++; else m_misses++;
        end
        if (ins_land) void'(ins_q.pop_front());
        if (g_lk) lk_q.push_back(cyc);
        if (g_ev) ins_q.push_back(cyc);
        if (g_lk || g_ev) m_last_ins = g_ev;
        if (m_wb_full && s_wb_ready) m_wb_full = 0;
        if (cap) begin
            m_wb_full = 1;
            m_wb_data = s_block;
        end
        m_after_rst = 0;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
        reset              = s_reset;
        bus.lk_req_valid   = s_lk_v;
        bus.lk_page_offset = s_lk_off;
        bus.ev_req_valid   = s_ev_v;
        bus.ev_page_offset = s_ev_off;
        bus.ev_data        = s_ev_data;
        bus.vc_is_found    = s_found;
        bus.vc_byte_out    = s_byte;
        bus.vc_block_out   = s_block;
        bus.wb_ready       = s_wb_ready;
        @(negedge clk);
        model_check();
        cyc++;
    endtask

    task automatic idle();
        s_reset    = 0;
        s_lk_v     = 0;
        s_ev_v     = 0;
        s_found    = 0;
        s_byte     = 8'h00;
        s_block    = '0;
        s_wb_ready = 1;
    endtask

    initial begin
        reset              = 1;
        bus.lk_req_valid   = 0;
        bus.lk_page_offset = '0;
        bus.ev_req_valid   = 0;
        bus.ev_page_offset = '0;
        bus.ev_data        = '0;
        bus.vc_is_found    = 0;
        bus.vc_byte_out    = '0;
        bus.vc_block_out   = '0;
        bus.wb_ready       = 0;
        idle();
        s_lk_off  = 12'h000;
        s_ev_off  = 12'h000;
        s_ev_data = '0;

        // Reset, then a lookup at cycle 10 that hits with byte A7.
        s_reset = 1;
        repeat (3) do_cycle();
        idle();
        while (cyc < 10) do_cycle();
        s_lk_v = 1; s_lk_off = 12'h0C5;
        do_cycle();
        check("d1_vc_off", bus.vc_page_offset, 12'h0C5);
        s_lk_v = 0;
        repeat (2) do_cycle();
        s_found = 1; s_byte = 8'hA7;
        do_cycle();
        check("d1_rsp_valid", bus.lk_rsp_valid, 1);
        check("d1_rsp_hit", bus.lk_rsp_hit, 1);
        check("d1_rsp_byte", bus.lk_rsp_byte, 8'hA7);
        idle();
        do_cycle();
        check("d1_pulse_end", bus.lk_rsp_valid, 0);

        // Both requesters from idle after reset: lookup first, then insert.
        s_reset = 1;
        repeat (2) do_cycle();
        idle();
        s_lk_v = 1; s_lk_off = 12'h111; s_ev_v = 1; s_ev_off = 12'h222; s_ev_data = rand512();
        do_cycle();
        check("d2_post_rst_lk", bus.lk_req_ready, 0);
        do_cycle();
        check("d2_first_lk", bus.lk_req_ready, 1);
        check("d2_first_ev", bus.ev_req_ready, 0);
        do_cycle();
        check("d2_second_ev", bus.ev_req_ready, 1);
        repeat (10) do_cycle();

        // Insert that evicts a victim while L2 stalls for five cycles.
        idle();
        repeat (4) do_cycle();
        s_ev_v = 1; s_ev_off = 12'h3A0; s_ev_data = rand512();
        do_cycle();
        check("d3_issue", bus.ev_req_ready, 1);
        repeat (2) do_cycle();
        s_found = 1; s_block = {64{8'h5A}}; s_wb_ready = 0;
        do_cycle();
        check("d3_land_ev_ready", bus.ev_req_ready, 0);
        s_found = 0; s_block = '0;
        repeat (5) begin
            do_cycle();
            check("d3_wb_valid", bus.wb_valid, 1);
            check("d3_wb_data", bus.wb_data, {64{8'h5A}});
            check("d3_ev_blocked", bus.ev_req_ready, 0);
        end
        s_wb_ready = 1;
        do_cycle();
        check("d3_handshake", bus.wb_valid, 1);
        do_cycle();
        check("d3_wb_drained", bus.wb_valid, 0);
        check("d3_ev_again", bus.ev_req_ready, 1);
        idle();
        repeat (4) do_cycle();

        // Insert with no victim: ready returns in the landing cycle.
        s_ev_v = 1; s_ev_off = 12'h5C4; s_ev_data = rand512();
        do_cycle();
        repeat (2) do_cycle();
        s_found = 0;
        do_cycle();
        check("d4_ev_ready_back", bus.ev_req_ready, 1);
        check("d4_no_wb", bus.wb_valid, 0);
        idle();
        repeat (5) do_cycle();
        check("d4_still_no_wb", bus.wb_valid, 0);

        // Reset one cycle after a lookup drops its response.
        s_lk_v = 1; s_lk_off = 12'h777;
        do_cycle();
        idle();
        s_reset = 1;
        do_cycle();
        s_reset = 0;
        do_cycle();
        s_found = 1; s_byte = 8'h3C;
        do_cycle();
        check("d5_no_rsp", bus.lk_rsp_valid, 0);
        check("d5_no_hit", bus.lk_rsp_hit, 0);
        check("d5_byte_zero", bus.lk_rsp_byte, 0);
        check("d5_wb_zero", bus.wb_valid, 0);
        idle();
        do_cycle();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            s_reset    = ($urandom_range(0, 199) == 0);
            s_lk_v     = $urandom_range(0, 1);
            s_lk_off   = 12'($urandom);
            s_ev_v     = $urandom_range(0, 1);
            s_ev_off   = 12'($urandom);
            s_ev_data  = rand512();
            s_found    = $urandom_range(0, 1);
            s_byte     = 8'($urandom);
            s_block    = rand512();
            s_wb_ready = ($urandom_range(0, 9) < 6);
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
